// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace session controller.
package trdb_pkg;
  localparam int CTRL_CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE, ARMED, START, TRACING, STOP, DRAIN
  } ctrl_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE, CAUSE_USER, CAUSE_EVENT, CAUSE_COUNT
  } stop_cause_e;
endpackage

// File: rtl/trdb_trace_ctrl_if.sv
// Start/stop packet request handshakes between the session controller and the packet emitter.
interface trdb_trace_ctrl_if;
  // valid rises only from the requester and stays high until the cycle ready is seen high;
  // a transfer happens in every cycle where both are high (including the first valid cycle).
  logic start_pkt_valid;
  logic start_pkt_ready;
  logic stop_pkt_valid;
  logic stop_pkt_ready;

  modport master (
    output start_pkt_valid, stop_pkt_valid,
    input  start_pkt_ready, stop_pkt_ready
  );

  modport slave (
    input  start_pkt_valid, stop_pkt_valid,
    output start_pkt_ready, stop_pkt_ready
  );
endinterface

// File: rtl/trdb_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module trdb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/trdb_trace_ctrl.sv
// Trace session sequencer: arm, start packet, trace, stop packet, drain.
// Every output is a flop or a pure decode of the state register.
module trdb_trace_ctrl
  import trdb_pkg::*;
#(
  parameter int CNT_W    = CTRL_CNT_W,
  parameter int DRAIN_TO = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trace_enable_i,
  input  logic              arm_on_range_i,
  input  logic              ivalid_i,
  input  logic              range_match_i,
  input  logic              req_deactivate_i,
  input  logic [CNT_W-1:0]  stop_count_i,
  input  logic              fifo_empty_i,
  trdb_trace_ctrl_if.master pkt_if,
  output logic              trace_activated_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  instr_count_o,
  output logic [1:0]        stop_cause_o,
  output logic              drain_timeout_o,
  output ctrl_state_e       dbg_state_o
);
  localparam int               TMR_W    = $clog2(DRAIN_TO) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TO - 1);

  ctrl_state_e      state_q, state_d;
  stop_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             done_q, done_d;
  logic             dto_q, dto_d;
  logic             cnt_clr, cnt_inc, tmr_clr, tmr_inc;
  logic [CNT_W-1:0] cnt_q;
  logic [TMR_W-1:0] tmr_q;

  trdb_sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .inc_i(cnt_inc), .cnt_o(cnt_q)
  );

  trdb_sat_counter #(.W(TMR_W)) u_drain_tmr (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(tmr_clr), .inc_i(tmr_inc), .cnt_o(tmr_q)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    lim_d   = lim_q;
    done_d  = done_q;
    dto_d   = dto_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    tmr_clr = 1'b1;
    tmr_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (trace_enable_i && !done_q) state_d = arm_on_range_i ? ARMED : START;
      end
      ARMED: begin
        if (!trace_enable_i)                state_d = IDLE;
        else if (ivalid_i && range_match_i) state_d = START;
      end
      START: begin
        // The start request is never withdrawn; a dropped enable only redirects to STOP.
        if (pkt_if.start_pkt_ready) begin
          lim_d   = stop_count_i;
          cnt_clr = 1'b1;
          if (!trace_enable_i) begin
            state_d = STOP;
            cause_d = CAUSE_USER;
          end else begin
            state_d = TRACING;
            cause_d = CAUSE_NONE;
          end
        end
      end
      TRACING: begin
        cnt_inc = ivalid_i;
        if (!trace_enable_i) begin
          state_d = STOP;
          cause_d = CAUSE_USER;
        end else if (ivalid_i && req_deactivate_i) begin
          state_d = STOP;
          cause_d = CAUSE_EVENT;
        end else if (ivalid_i && (lim_q != '0) && ((cnt_q + CNT_W'(1)) == lim_q)) begin
          state_d = STOP;
          cause_d = CAUSE_COUNT;
        end
      end
      STOP: begin
        if (cause_q == CAUSE_EVENT || cause_q == CAUSE_COUNT) done_d = 1'b1;
        if (pkt_if.stop_pkt_ready) state_d = DRAIN;
      end
      DRAIN: begin
        tmr_clr = 1'b0;
        tmr_inc = 1'b1;
        if (fifo_empty_i) begin
          state_d = IDLE;
          dto_d   = 1'b0;
        end else if (tmr_q == TMR_LAST) begin
          state_d = IDLE;
          dto_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // An automatic stop must not retrigger until the user toggles the enable.
    if (!trace_enable_i) done_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      lim_q   <= '0;
      done_q  <= 1'b0;
      dto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      lim_q   <= lim_d;
      done_q  <= done_d;
      dto_q   <= dto_d;
    end
  end

  assign pkt_if.start_pkt_valid = (state_q == START);
  assign pkt_if.stop_pkt_valid  = (state_q == STOP);
  assign trace_activated_o      = (state_q == TRACING);
  assign busy_o                 = (state_q != IDLE);
  assign instr_count_o          = cnt_q;
  assign stop_cause_o           = cause_q;
  assign drain_timeout_o        = dto_q;
  assign dbg_state_o            = state_q;
endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Randomised and directed scenarios for the trace session controller.
module tb_trdb_trace_ctrl;
  import trdb_pkg::*;

  localparam int CNT_W    = 32;
  localparam int DRAIN_TO = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, arm, iv, rm, deact, fifo_empty;
  logic [CNT_W-1:0] stop_count;
  logic             act, busy, dto;
  logic [CNT_W-1:0] instr_count;
  logic [1:0]       stop_cause;
  ctrl_state_e      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W+1:0] exp_q[$];

  trdb_trace_ctrl_if pkt_if ();

  trdb_trace_ctrl #(.CNT_W(CNT_W), .DRAIN_TO(DRAIN_TO)) dut (
    .clk_i(clk), .rst_i(rst), .trace_enable_i(en), .arm_on_range_i(arm),
    .ivalid_i(iv), .range_match_i(rm), .req_deactivate_i(deact),
    .stop_count_i(stop_count), .fifo_empty_i(fifo_empty), .pkt_if(pkt_if),
    .trace_activated_o(act), .busy_o(busy), .instr_count_o(instr_count),
    .stop_cause_o(stop_cause), .drain_timeout_o(dto), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    en = 0; arm = 0; iv = 0; rm = 0; deact = 0; stop_count = '0; fifo_empty = 1;
    pkt_if.start_pkt_ready = 1;
    pkt_if.stop_pkt_ready  = 1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    int c = 0;
    while (busy && c < max) begin
      step();
      c++;
    end
    ok = !busy;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({busy, act, pkt_if.start_pkt_valid, pkt_if.stop_pkt_valid, stop_cause, dto, instr_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b act=%b sv=%b pv=%b cause=%0d dto=%b cnt=%0d, required all 0",
               busy, act, pkt_if.start_pkt_valid, pkt_if.stop_pkt_valid, stop_cause, dto, instr_count);
    end
  endtask

  task automatic test_plain();
    int act_cnt = 0;
    bit ok;
    do_reset();
    en = 1;
    step();
    n_tests++;
    if ({pkt_if.start_pkt_valid, act} !== 2'b10) begin
      n_fail++;
      $display("FAIL plain_start_valid: sv=%b act=%b, required sv=1 act=0", pkt_if.start_pkt_valid, act);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      if (act) act_cnt++;
      iv = 1;
      step();
    end
    iv = 0; en = 0;
    n_tests++;
    if (act_cnt !== 10) begin
      n_fail++;
      $display("FAIL plain_activated: %0d cycles, required 10", act_cnt);
    end
    step();
    n_tests++;
    if ({pkt_if.stop_pkt_valid, act, stop_cause, instr_count} !== {1'b1, 1'b0, 2'd1, 32'd10}) begin
      n_fail++;
      $display("FAIL plain_stop: pv=%b act=%b cause=%0d cnt=%0d, required 1 0 1 10",
               pkt_if.stop_pkt_valid, act, stop_cause, instr_count);
    end
    wait_idle(10, ok);
    n_tests++;
    if (!ok || dto !== 1'b0) begin
      n_fail++;
      $display("FAIL plain_idle: idle=%b dto=%b, required idle=1 dto=0", ok, dto);
    end
  endtask

  task automatic test_range_arm();
    int bad = 0;
    bit ok;
    do_reset();
    arm = 1; en = 1; iv = 1; rm = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (pkt_if.start_pkt_valid || act || !busy) bad++;
      step();
    end
    n_tests++;
    if (bad != 0 || pkt_if.start_pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_wait: bad=%0d sv=%b, required 0 0", bad, pkt_if.start_pkt_valid);
    end
    rm = 1;
    step();
    rm = 0; iv = 0;
    n_tests++;
    if ({pkt_if.start_pkt_valid, act} !== 2'b10) begin
      n_fail++;
      $display("FAIL arm_start: sv=%b act=%b, required 1 0", pkt_if.start_pkt_valid, act);
    end
    step();
    n_tests++;
    if (act !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_activated: act=%b, required 1", act);
    end
    en = 0;
    wait_idle(10, ok);
    n_tests++;
    if (!ok || stop_cause !== 2'd1 || instr_count !== '0) begin
      n_fail++;
      $display("FAIL arm_end: idle=%b cause=%0d cnt=%0d, required 1 1 0", ok, stop_cause, instr_count);
    end
  endtask

  task automatic test_count_stop();
    int icount = 0, c = 0, bad = 0;
    bit ok;
    do_reset();
    en = 1; stop_count = 4;
    step();
    step();
    stop_count = 100;
    while (act && c < 60) begin
      iv = ($urandom_range(0, 2) != 0);
      if (iv) icount++;
      step();
      c++;
    end
    iv = 0;
    n_tests++;
    if (icount != 4 || instr_count !== 32'd4 || stop_cause !== 2'd3) begin
      n_fail++;
      $display("FAIL count_stop: driven=%0d cnt=%0d cause=%0d, required 4 4 3", icount, instr_count, stop_cause);
    end
    wait_idle(10, ok);
    for (int i = 0; i < 5; i++) begin
      if (busy) bad++;
      step();
    end
    n_tests++;
    if (!ok || bad != 0) begin
      n_fail++;
      $display("FAIL count_done_block: idle=%b busy_cycles=%0d, required 1 0", ok, bad);
    end
    en = 0;
    step();
    en = 1;
    step();
    n_tests++;
    if (pkt_if.start_pkt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL count_retrigger: sv=%b, required 1", pkt_if.start_pkt_valid);
    end
    en = 0;
    wait_idle(10, ok);
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    en = 1; stop_count = 3;
    step();
    step();
    iv = 1;
    step();
    step();
    en = 0; deact = 1;
    step();
    iv = 0; deact = 0;
    n_tests++;
    if ({pkt_if.stop_pkt_valid, stop_cause, instr_count} !== {1'b1, 2'd1, 32'd3}) begin
      n_fail++;
      $display("FAIL simultaneous: pv=%b cause=%0d cnt=%0d, required 1 1 3",
               pkt_if.stop_pkt_valid, stop_cause, instr_count);
    end
    wait_idle(10, ok);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bit ok;
    do_reset();
    pkt_if.start_pkt_ready = 0;
    en = 1;
    step();
    for (int i = 1; i <= 7; i++) begin
      if (pkt_if.start_pkt_valid !== 1'b1) bad++;
      if (i == 3) en = 0;
      step();
    end
    n_tests++;
    if (bad != 0 || pkt_if.start_pkt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid_hold: dropped=%0d sv=%b, required 0 1", bad, pkt_if.start_pkt_valid);
    end
    pkt_if.start_pkt_ready = 1;
    step();
    n_tests++;
    if ({pkt_if.stop_pkt_valid, act, stop_cause} !== {1'b1, 1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL bp_stop: pv=%b act=%b cause=%0d, required 1 0 1", pkt_if.stop_pkt_valid, act, stop_cause);
    end
    wait_idle(10, ok);
  endtask

  task automatic test_drain_timeout();
    int dcyc = 0;
    do_reset();
    fifo_empty = 0; en = 1;
    step();
    step();
    iv = 1;
    step();
    iv = 0; en = 0;
    step();
    step();
    while (busy && dcyc < 200) begin
      dcyc++;
      step();
    end
    n_tests++;
    if (dcyc != DRAIN_TO || busy !== 1'b0 || dto !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_timeout: cycles=%0d busy=%b dto=%b, required %0d 0 1", dcyc, busy, dto, DRAIN_TO);
    end
  endtask

  task automatic test_reset_in_tracing();
    en = 1; stop_count = '0;
    step();
    step();
    iv = 1;
    step();
    step();
    iv = 0;
    n_tests++;
    if (act !== 1'b1 || instr_count !== 32'd2) begin
      n_fail++;
      $display("FAIL rst_pre: act=%b cnt=%0d, required 1 2", act, instr_count);
    end
    rst = 1;
    step();
    rst = 0;
    n_tests++;
    if ({busy, act, pkt_if.start_pkt_valid, pkt_if.stop_pkt_valid, stop_cause, dto, instr_count} !== '0) begin
      n_fail++;
      $display("FAIL rst_in_tracing: busy=%b act=%b cause=%0d dto=%b cnt=%0d, required all 0",
               busy, act, stop_cause, dto, instr_count);
    end
    drive_idle();
    step();
  endtask

  task automatic test_random_sessions();
    bit iv_a[32], dv_a[32];
    int lim, user, stop_at, ev_at, cnt_at, seen, cause, count, act_cnt, bad, d;
    logic [CNT_W+1:0] e;
    bit ok;
    do_reset();
    for (int s = 0; s < 20; s++) begin
      lim  = $urandom_range(0, 8);
      user = $urandom_range(4, 31);
      for (int c = 0; c < 32; c++) begin
        iv_a[c] = ($urandom_range(0, 3) != 0);
        dv_a[c] = ($urandom_range(0, 11) == 0);
      end
      // reference: earliest of user drop, first deactivating instruction, lim-th instruction
      ev_at = 99; cnt_at = 99; seen = 0;
      for (int c = 0; c < 32; c++) begin
        if (iv_a[c] && dv_a[c] && ev_at == 99) ev_at = c;
        if (iv_a[c]) begin
          seen++;
          if (lim != 0 && seen == lim && cnt_at == 99) cnt_at = c;
        end
      end
      stop_at = user;
      if (ev_at < stop_at) stop_at = ev_at;
      if (cnt_at < stop_at) stop_at = cnt_at;
      cause = (stop_at == user) ? 1 : (stop_at == ev_at) ? 2 : 3;
      count = 0;
      for (int c = 0; c <= stop_at; c++) count += int'(iv_a[c]);
      exp_q.push_back({2'(cause), CNT_W'(count)});

      en = 1; stop_count = CNT_W'(lim); fifo_empty = 0;
      pkt_if.start_pkt_ready = 0; pkt_if.stop_pkt_ready = 0;
      step();
      bad = 0;
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        if (pkt_if.start_pkt_valid !== 1'b1) bad++;
        step();
      end
      pkt_if.start_pkt_ready = 1;
      step();
      pkt_if.start_pkt_ready = 0;
      act_cnt = 0;
      for (int c = 0; c <= stop_at; c++) begin
        if (act) act_cnt++;
        en = (c < user); iv = iv_a[c]; deact = dv_a[c];
        step();
      end
      iv = 0; deact = 0;
      n_tests++;
      if (act_cnt != stop_at + 1 || act !== 1'b0 || pkt_if.stop_pkt_valid !== 1'b1 || bad != 0) begin
        n_fail++;
        $display("FAIL rand_window s=%0d: act_cycles=%0d act=%b pv=%b sv_drops=%0d, required %0d 0 1 0",
                 s, act_cnt, act, pkt_if.stop_pkt_valid, bad, stop_at + 1);
      end
      e = exp_q.pop_front();
      n_tests++;
      if ({stop_cause, instr_count} !== e) begin
        n_fail++;
        $display("FAIL rand_result s=%0d: cause=%0d cnt=%0d, required cause=%0d cnt=%0d",
                 s, stop_cause, instr_count, e[CNT_W+1:CNT_W], e[CNT_W-1:0]);
      end
      d = $urandom_range(0, 3);
      bad = 0;
      for (int i = 0; i < d; i++) begin
        if (pkt_if.stop_pkt_valid !== 1'b1) bad++;
        step();
      end
      pkt_if.stop_pkt_ready = 1;
      step();
      pkt_if.stop_pkt_ready = 0;
      d = $urandom_range(0, 20);
      for (int i = 0; i < d; i++) step();
      fifo_empty = 1;
      wait_idle(10, ok);
      n_tests++;
      if (!ok || dto !== 1'b0 || bad != 0) begin
        n_fail++;
        $display("FAIL rand_drain s=%0d: idle=%b dto=%b pv_drops=%0d, required 1 0 0", s, ok, dto, bad);
      end
      if (cause != 1) begin
        step();
        step();
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_done_block s=%0d: busy=%b, required 0", s, busy);
        end
      end
      en = 0;
      step();
      step();
    end
  endtask

  // sequence and final report
  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_plain();
    test_range_arm();
    test_count_stop();
    test_simultaneous();
    test_backpressure();
    test_drain_timeout();
    test_reset_in_tracing();
    test_random_sessions();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
